// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter feeding the packet parser bus.
// Holds the granted port from SOP to EOP, then inserts an idle gap.
module packet_arbiter #(
    parameter int NUM_PORTS        = 4,
    parameter int WIDTH_DATA_BYTES = 8,
    parameter int IDLE_GAP_CYCLES  = 1
) (
    input  logic                                    clk_host,
    input  logic                                    rst,
    input  logic [NUM_PORTS-1:0]                    in_valid,
    input  logic [NUM_PORTS-1:0]                    in_sop,
    input  logic [NUM_PORTS-1:0]                    in_eop,
    input  logic [NUM_PORTS*WIDTH_DATA_BYTES-1:0]   in_byteen,
    input  logic [NUM_PORTS*WIDTH_DATA_BYTES*8-1:0] in_data,
    output logic [NUM_PORTS-1:0]                    in_ready,
    output logic                                    bus_out_valid,
    output logic                                    bus_out_sop,
    output logic                                    bus_out_eop,
    output logic [WIDTH_DATA_BYTES-1:0]             bus_out_byteen,
    output logic [WIDTH_DATA_BYTES*8-1:0]           bus_out_data,
    output logic [$clog2(NUM_PORTS)-1:0]            grant_id,
    output logic                                    busy,
    output logic                                    proto_err
);

    localparam int WB = WIDTH_DATA_BYTES * 8;
    localparam int IW = $clog2(NUM_PORTS);
    localparam int GW = (IDLE_GAP_CYCLES > 0) ? $clog2(IDLE_GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD =
        (IDLE_GAP_CYCLES > 0) ? GW'(IDLE_GAP_CYCLES - 1) : '0;
    localparam logic [IW-1:0] LAST = IW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic                    first_q, first_d;
    logic                    perr_q, perr_d;
    logic                    ov_q, ov_d;
    logic                    osop_q, osop_d;
    logic                    oeop_q, oeop_d;
    logic [WIDTH_DATA_BYTES-1:0] obe_q, obe_d;
    logic [WB-1:0]           odata_q, odata_d;

    logic [NUM_PORTS-1:0]    req;
    logic [IW-1:0]           pick;
    logic [IW-1:0]           idx;
    logic                    found;

    logic                    cur_valid;
    logic                    cur_sop;
    logic                    cur_eop;
    logic [WIDTH_DATA_BYTES-1:0] cur_be;
    logic [WB-1:0]           cur_data;

    // Circular first-set search over SOP requests starting at rr_ptr.
    always_comb begin
        req   = in_valid & in_sop;
        pick  = '0;
        found = 1'b0;
        idx   = rr_ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = (idx == LAST) ? '0 : idx + IW'(1);
        end
    end

    // Mux the granted port's beat.
    always_comb begin
        cur_valid = in_valid[grant_q];
        cur_sop   = in_sop[grant_q];
        cur_eop   = in_eop[grant_q];
        cur_be    = in_byteen[int'(grant_q)*WIDTH_DATA_BYTES +: WIDTH_DATA_BYTES];
        cur_data  = in_data[int'(grant_q)*WB +: WB];
    end

    // Only the owner of the current packet is ready, and only in XFER.
    always_comb begin
        in_ready = '0;
        if (state_q == XFER) begin
            in_ready[grant_q] = 1'b1;
        end
    end

    // Next-state, pointer and output-register logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        gap_cnt_d = gap_cnt_q;
        first_d   = first_q;
        perr_d    = perr_q;
        ov_d      = 1'b0;
        osop_d    = 1'b0;
        oeop_d    = 1'b0;
        obe_d     = '0;
        odata_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    first_d = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (cur_valid) begin
                    ov_d    = 1'b1;
                    osop_d  = cur_sop;
                    oeop_d  = cur_eop;
                    obe_d   = cur_be;
                    odata_d = cur_data;
                    first_d = 1'b0;
                    if (cur_sop && !first_q) begin
                        perr_d = 1'b1;
                    end
                    if (cur_eop) begin
                        rr_ptr_d = (grant_q == LAST) ? '0 : grant_q + IW'(1);
                        if (IDLE_GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_host) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            gap_cnt_q <= '0;
            first_q   <= 1'b0;
            perr_q    <= 1'b0;
            ov_q      <= 1'b0;
            osop_q    <= 1'b0;
            oeop_q    <= 1'b0;
            obe_q     <= '0;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            gap_cnt_q <= gap_cnt_d;
            first_q   <= first_d;
            perr_q    <= perr_d;
            ov_q      <= ov_d;
            osop_q    <= osop_d;
            oeop_q    <= oeop_d;
            obe_q     <= obe_d;
            odata_q   <= odata_d;
        end
    end

    assign bus_out_valid  = ov_q;
    assign bus_out_sop    = osop_q;
    assign bus_out_eop    = oeop_q;
    assign bus_out_byteen = obe_q;
    assign bus_out_data   = odata_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q == XFER);
    assign proto_err      = perr_q;

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

- Packet-granular round-robin arbiter that merges `NUM_PORTS` packet streams onto the single input bus of the packet parser.
- Once an input wins, it holds the bus from SOP through EOP. No interleaving between inputs.
- Per-input `in_ready` provides backpressure. The output bus has none, because the parser cannot stall.
- A programmable idle gap after every packet gives the parser's header counter and output stage time to retire before the next SOP.

## Interface
- `NUM_PORTS`, default 4: number of requesting streams; must be ≥ 2.
- `WIDTH_DATA_BYTES`, default 8: bus width in bytes; WIDTH_DATA_BITS = WIDTH_DATA_BYTES*8.
- `IDLE_GAP_CYCLES`, default 1: idle output cycles inserted after each EOP; 0 is legal.
- `clk_host` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in NUM_PORTS: per-port beat valid.
- `in_sop` in NUM_PORTS: per-port start of packet.
- `in_eop` in NUM_PORTS: per-port end of packet.
- `in_byteen` in NUM_PORTS*WIDTH_DATA_BYTES: port p occupies bits [p*WIDTH_DATA_BYTES +: WIDTH_DATA_BYTES].
- `in_data` in NUM_PORTS*WIDTH_DATA_BITS: port p occupies bits [p*WIDTH_DATA_BITS +: WIDTH_DATA_BITS].
- `in_ready` out NUM_PORTS: per-port accept; combinational from state.
- `bus_out_valid` out 1: registered beat valid, to parser `bus_in_valid`.
- `bus_out_sop` out 1: registered start of packet.
- `bus_out_eop` out 1: registered end of packet.
- `bus_out_byteen` out WIDTH_DATA_BYTES: registered byte enables.
- `bus_out_data` out WIDTH_DATA_BITS: registered data.
- `grant_id` out $clog2(NUM_PORTS): port owning the current packet; valid while `busy`.
- `busy` out 1: high in state XFER.
- `proto_err` out 1: sticky protocol-error flag, cleared only by `rst`.

## Operation
- A beat on port p transfers when in_valid[p] && in_ready[p].
- in_ready[p] = (state == XFER) && (grant_id == p). All other ports see 0.
- Requesting ports hold their beat until it transfers.
- **IDLE**
  - req = in_valid & in_sop.
  - If req != 0, pick the first set bit scanning circularly from rr_ptr. Register grant_id and go to XFER.
  - If req == 0, stay in IDLE.
  - Valid beats without SOP are ignored and never accepted.
- **XFER**
  - Every transferred beat is registered onto bus_out_* on the next edge.
  - A transfer with in_eop sets rr_ptr = (grant_id+1) mod NUM_PORTS.
  - After that EOP transfer, go to GAP if IDLE_GAP_CYCLES > 0, else to IDLE.
  - A cycle with in_valid[grant_id] = 0 is a bubble: bus_out_valid = 0 on the next cycle, state held.
  - SOP on a beat other than the packet's first sets proto_err. The beat is still forwarded, and the packet ends only at EOP.
- **GAP**
  - gap_cnt loads IDLE_GAP_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE.
  - No port is ready during GAP.
- Single-beat packet (SOP && EOP on one beat): one XFER cycle, then GAP or IDLE.
- Output qualification: when bus_out_valid = 0, bus_out_sop, bus_out_eop, bus_out_byteen and bus_out_data are all 0.
- Counter widths:
  - rr_ptr and grant_id are $clog2(NUM_PORTS) bits; wrap from NUM_PORTS-1 to 0, including non-power-of-2 NUM_PORTS.
  - gap_cnt is max(1, $clog2(IDLE_GAP_CYCLES+1)) bits.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, grant_id = 0, gap_cnt = 0.
  - All bus_out_* = 0, busy = 0, proto_err = 0.
  - in_ready = 0 on the cycle after the reset edge.
- Reset asserted mid-packet: XFER is abandoned at the next edge. No EOP is emitted; the parser is reset by the same `rst` domain.
- Latency:
  - SOP presented at cycle t with the bus idle: state is XFER at t+1, the beat is accepted at t+1, and appears on bus_out at t+2.
  - Later beats appear on bus_out one cycle after their accept.
- Back-to-back cost per packet: 1 arbitration cycle + L beats + IDLE_GAP_CYCLES.
- Minimum output spacing: EOP on bus_out at cycle e gives the next SOP on bus_out at cycle e + IDLE_GAP_CYCLES + 2 at the earliest.
- Simultaneous events:
  - A new SOP arriving on another port during XFER or GAP waits; it is evaluated in the next IDLE.
  - Requests arriving on the same cycle are resolved purely by rr_ptr order.
- Fairness: a port with a continuously pending SOP is granted within NUM_PORTS packets.

## Test plan
- Single packet: NUM_PORTS=4, port 2 sends 3 beats with data 0xA0, 0xA1, 0xA2 and eop byteen 0x0F, SOP at t.
  - in_ready[2] is high at t+1..t+3.
  - bus_out shows sop+0xA0 at t+2 and eop+0xA2 with byteen 0x0F at t+4.
  - grant_id = 2.
- All four ports request SOP on the same cycle after reset:
  - Grants go 0, 1, 2, 3, then back to 0.
  - Each 2-beat packet is separated by exactly one output-idle cycle plus the arbitration cycle (IDLE_GAP_CYCLES=1).
- IDLE_GAP_CYCLES=0 with back-to-back single-beat packets on ports 1 and 3:
  - Output SOP/EOP beats appear two cycles apart.
  - rr_ptr goes 2, then 0.
- Port 0 mid-packet with in_valid deasserted for 2 cycles:
  - bus_out_valid drops for exactly 2 cycles.
  - Port 1's pending SOP is not accepted until port 0's EOP plus the gap has elapsed.
- Stray SOP on the third beat of a granted packet:
  - proto_err rises one cycle after the accept and stays high.
  - The beat is forwarded and the packet still ends at its EOP.
- `rst` asserted during the second beat of a 5-beat packet:
  - Next cycle: all outputs are 0 and state is IDLE.
  - A subsequent SOP on port 3 is granted first (rr_ptr = 0, and port 3 is the only requester).
